// File: rtl/menu_pkg.sv
// menu_pkg: menu command byte constants and receiver state type (S_PARITY exists only with ARDUINO_RX_PARITY_EN)
package menu_pkg;
  localparam logic [7:0] CMD_RIGHT   = 8'h52;
  localparam logic [7:0] CMD_LEFT    = 8'h4C;
  localparam logic [7:0] CMD_CONFIRM = 8'h0D;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
`ifdef ARDUINO_RX_PARITY_EN
    , S_PARITY
`endif
  } rx_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronized UART byte receiver (8N1, or 8E1 with ARDUINO_RX_PARITY_EN) with valid/error pulses and held code
module uart_rx_core
  import menu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       valid,
  output logic       err,
  output logic [7:0] code
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
`ifdef ARDUINO_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = S_PARITY;
`else
  localparam rx_state_e AFTER_DATA = S_STOP;
`endif
  rx_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d, vld_q, vld_d;
  logic prev_q, prev_d, valid_q, valid_d, err_q, err_d, bad_q, bad_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, code_q, code_d;
  logic rx_s, fall, tick;
  assign rx_s  = sync_q[1];
  assign fall  = prev_q & ~rx_s;
  assign tick  = cnt_q == LAST;
  assign valid = valid_q;
  assign err   = err_q;
  assign code  = code_q;
  always_comb begin
    sync_d  = {sync_q[0], rx};
    vld_d   = {vld_q[0], 1'b1};
    prev_d  = rx_s & vld_q[1];
    state_d = state_q;
    cnt_d   = cnt_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = fall ? S_START : S_IDLE;
      end
      S_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? AFTER_DATA : S_DATA;
      end
`ifdef ARDUINO_RX_PARITY_EN
      S_PARITY: if (tick) begin
        cnt_d   = '0;
        bad_d   = rx_s ^ (^shift_q);
        state_d = S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        cnt_d   = '0;
        bad_d   = 1'b0;
        valid_d = rx_s & ~bad_q;
        err_d   = ~rx_s | bad_q;
        code_d  = (rx_s & ~bad_q) ? shift_q : code_q;
        state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        cnt_d   = '0;
        state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: Arduino UART menu command receiver with stretched key presses (ARDUINO_RX_PARITY_EN selects 8E1 frames)
module arduino_cmd_rx
  import menu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PRESS_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arduino_rx,
  output logic       right_arrow_pressed,
  output logic       left_arrow_pressed,
  output logic       confirm_pressed,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       frame_error
);
  localparam int PW = $clog2(PRESS_CYCLES + 1);
  logic [PW-1:0] cnt_q, cnt_d;
  logic [2:0] key_q, key_d, hit;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clock(clock),
    .reset(reset),
    .rx   (arduino_rx),
    .valid(cmd_valid),
    .err  (frame_error),
    .code (cmd_code)
  );
  always_comb begin
    hit   = {cmd_code == CMD_CONFIRM, cmd_code == CMD_LEFT, cmd_code == CMD_RIGHT};
    key_d = (cmd_valid && hit != 3'b000) ? hit : key_q;
    cnt_d = (cmd_valid && hit != 3'b000) ? PW'(PRESS_CYCLES) : (cnt_q != '0) ? cnt_q - PW'(1) : '0;
  end
  assign {confirm_pressed, left_arrow_pressed, right_arrow_pressed} = key_q & {3{cnt_q != '0}};
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      key_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb_arduino_cmd_rx: randomized self-checking bench for arduino_cmd_rx against a frame-level reference model
module tb_arduino_cmd_rx;
  localparam int C = 16;
  localparam int P = 4;
`ifdef ARDUINO_RX_PARITY_EN
  localparam int FRAME = 11 * C;
`else
  localparam int FRAME = 10 * C;
`endif
  logic clock = 1'b0, reset = 1'b1, arduino_rx = 1'b1;
  logic right_arrow_pressed, left_arrow_pressed, confirm_pressed, cmd_valid, frame_error;
  logic [7:0] cmd_code;
  int compared = 0, mismatched = 0;
  int cyc = 0, err_cnt = 0, overlap = 0;
  int valid_t[$], press_key[$], press_len[$];
  logic [7:0] valid_code[$];
  int run[3] = '{0, 0, 0};
  logic [2:0] keys;

  arduino_cmd_rx #(.CLKS_PER_BIT(C), .PRESS_CYCLES(P)) dut (
    .clock(clock), .reset(reset), .arduino_rx(arduino_rx),
    .right_arrow_pressed(right_arrow_pressed), .left_arrow_pressed(left_arrow_pressed),
    .confirm_pressed(confirm_pressed), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;
  assign keys = {confirm_pressed, left_arrow_pressed, right_arrow_pressed};

  always @(negedge clock) begin
    cyc++;
    if (cmd_valid === 1'b1) begin
      valid_t.push_back(cyc);
      valid_code.push_back(cmd_code);
    end
    if (frame_error === 1'b1) err_cnt++;
    if ($countones(keys) > 1) overlap++;
    for (int k = 0; k < 3; k++) begin
      if (keys[k] === 1'b1) run[k]++;
      else if (run[k] != 0) begin
        press_key.push_back(k);
        press_len.push_back(run[k]);
        run[k] = 0;
      end
    end
  end

  function automatic int key_of(input logic [7:0] b);
    return (b == 8'h52) ? 0 : (b == 8'h4C) ? 1 : (b == 8'h0D) ? 2 : -1;
  endfunction

  task automatic hold(input logic v, input int n);
    arduino_rx = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    valid_t.delete(); valid_code.delete(); press_key.delete(); press_len.delete();
    err_cnt = 0; overlap = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(b[i], C);
`ifdef ARDUINO_RX_PARITY_EN
    hold((^b) ^ par_flip, C);
`endif
    hold(stop_bit, C);
    arduino_rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arduino_rx = 1'b1;
    repeat (3) @(negedge clock);
    compared++;
    if ({right_arrow_pressed, left_arrow_pressed, confirm_pressed, cmd_valid, frame_error} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 00000", {right_arrow_pressed, left_arrow_pressed, confirm_pressed, cmd_valid, frame_error});
    end
    compared++;
    if (cmd_code !== 8'h00) begin mismatched++; $display("FAIL reset_code: got %h want 00", cmd_code); end
    reset = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_right();
    clear_log();
    send_frame(8'h52, 1'b1, 1'b0);
    hold(1'b1, 20);
    compared++;
    if (valid_t.size() != 1) begin mismatched++; $display("FAIL right_valid_count: got %0d want 1", valid_t.size()); end
    compared++;
    if (cmd_code !== 8'h52) begin mismatched++; $display("FAIL right_code: got %h want 52", cmd_code); end
    compared++;
    if (press_key.size() != 1 || press_key[0] != 0 || press_len[0] != P) begin
      mismatched++;
      $display("FAIL right_press: got n=%0d key=%0d len=%0d want n=1 key=0 len=%0d", press_key.size(),
               press_key.size() ? press_key[0] : -1, press_len.size() ? press_len[0] : -1, P);
    end
    compared++;
    if (err_cnt != 0 || overlap != 0) begin mismatched++; $display("FAIL right_clean: got err=%0d overlap=%0d want 0 0", err_cnt, overlap); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_frame(8'h4C, 1'b1, 1'b0);
    send_frame(8'h4C, 1'b1, 1'b0);
    hold(1'b1, 20);
    compared++;
    if (valid_t.size() != 2 || valid_t[1] - valid_t[0] != FRAME) begin
      mismatched++;
      $display("FAIL b2b_valid_spacing: got n=%0d dt=%0d want n=2 dt=%0d", valid_t.size(),
               valid_t.size() == 2 ? valid_t[1] - valid_t[0] : -1, FRAME);
    end
    compared++;
    if (press_key.size() != 2 || press_key[0] != 1 || press_key[1] != 1 || press_len[0] != P || press_len[1] != P) begin
      mismatched++;
      $display("FAIL b2b_presses: got n=%0d want two left presses of %0d", press_key.size(), P);
    end
  endtask

  task automatic test_stop_error();
    clear_log();
    send_frame(8'h41, 1'b0, 1'b0);
    hold(1'b0, 3 * C);
    compared++;
    if (err_cnt != 1 || valid_t.size() != 0) begin
      mismatched++;
      $display("FAIL stop_err_pulse: got err=%0d valid=%0d want 1 0", err_cnt, valid_t.size());
    end
    compared++;
    if (cmd_code !== 8'h4C) begin mismatched++; $display("FAIL stop_err_code: got %h want 4c", cmd_code); end
    hold(1'b1, 3 * C);
    compared++;
    if (err_cnt != 1 || valid_t.size() != 0 || press_key.size() != 0) begin
      mismatched++;
      $display("FAIL stop_err_break: got err=%0d valid=%0d press=%0d want 1 0 0", err_cnt, valid_t.size(), press_key.size());
    end
  endtask

  task automatic test_glitch();
    clear_log();
    hold(1'b0, 5);
    hold(1'b1, 3 * C);
    compared++;
    if (err_cnt != 0 || valid_t.size() != 0) begin
      mismatched++;
      $display("FAIL glitch_pulses: got err=%0d valid=%0d want 0 0", err_cnt, valid_t.size());
    end
    send_frame(8'h33, 1'b1, 1'b0);
    hold(1'b1, 20);
    compared++;
    if (valid_t.size() != 1 || valid_code[0] !== 8'h33 || press_key.size() != 0) begin
      mismatched++;
      $display("FAIL glitch_recover: got valid=%0d press=%0d code=%h want 1 0 33", valid_t.size(), press_key.size(), cmd_code);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h0D;
    clear_log();
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(b[i], C);
    hold(b[4], C / 2);
    reset = 1'b1; arduino_rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    hold(1'b1, 12 * C);
    compared++;
    if (err_cnt != 0 || valid_t.size() != 0 || press_key.size() != 0) begin
      mismatched++;
      $display("FAIL reset_mid_pulses: got err=%0d valid=%0d press=%0d want 0 0 0", err_cnt, valid_t.size(), press_key.size());
    end
    compared++;
    if (cmd_code !== 8'h00) begin mismatched++; $display("FAIL reset_mid_code: got %h want 00", cmd_code); end
    send_frame(8'h0D, 1'b1, 1'b0);
    hold(1'b1, 20);
    compared++;
    if (press_key.size() != 1 || press_key[0] != 2 || press_len[0] != P) begin
      mismatched++;
      $display("FAIL reset_mid_confirm: got n=%0d want one confirm press of %0d", press_key.size(), P);
    end
  endtask

  task automatic test_reset_low();
    clear_log();
    reset = 1'b1; arduino_rx = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    hold(1'b0, 15 * C);
    hold(1'b1, 3 * C);
    compared++;
    if (err_cnt != 0 || valid_t.size() != 0) begin
      mismatched++;
      $display("FAIL reset_low_start: got err=%0d valid=%0d want 0 0", err_cnt, valid_t.size());
    end
  endtask

`ifdef ARDUINO_RX_PARITY_EN
  task automatic test_parity();
    clear_log();
    send_frame(8'h52, 1'b1, 1'b1);
    hold(1'b1, 20);
    compared++;
    if (err_cnt != 1 || valid_t.size() != 0 || press_key.size() != 0) begin
      mismatched++;
      $display("FAIL parity_bad: got err=%0d valid=%0d press=%0d want 1 0 0", err_cnt, valid_t.size(), press_key.size());
    end
    send_frame(8'h52, 1'b1, 1'b0);
    hold(1'b1, 20);
    compared++;
    if (press_key.size() != 1 || press_key[0] != 0 || press_len[0] != P) begin
      mismatched++;
      $display("FAIL parity_good: got n=%0d want one right press", press_key.size());
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_codes[$];
    int exp_keys[$];
    int exp_err;
    logic [7:0] exp_last, b;
    logic stop_ok, par_flip;
    logic [7:0] pick[4];
    pick = '{8'h52, 8'h4C, 8'h0D, 8'h00};
    exp_err = 0;
    exp_last = cmd_code;
    clear_log();
    for (int n = 0; n < 24; n++) begin
      b = pick[$urandom_range(0, 3)];
      if (b == 8'h00) b = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
`ifdef ARDUINO_RX_PARITY_EN
      par_flip = ($urandom_range(0, 5) == 0);
`else
      par_flip = 1'b0;
`endif
      send_frame(b, stop_ok, par_flip);
      if (!stop_ok) hold(1'b0, $urandom_range(0, 2 * C));
      hold(1'b1, (stop_ok && !par_flip) ? $urandom_range(0, 30) : $urandom_range(4, 30));
      if (stop_ok && !par_flip) begin
        exp_codes.push_back(b);
        exp_last = b;
        if (key_of(b) >= 0) exp_keys.push_back(key_of(b));
      end else exp_err++;
    end
    hold(1'b1, 20);
    compared++;
    if (valid_t.size() != exp_codes.size()) begin
      mismatched++;
      $display("FAIL rand_valid_count: got %0d want %0d", valid_t.size(), exp_codes.size());
    end else for (int i = 0; i < exp_codes.size(); i++) begin
      compared++;
      if (valid_code[i] !== exp_codes[i]) begin mismatched++; $display("FAIL rand_code[%0d]: got %h want %h", i, valid_code[i], exp_codes[i]); end
    end
    compared++;
    if (press_key.size() != exp_keys.size()) begin
      mismatched++;
      $display("FAIL rand_press_count: got %0d want %0d", press_key.size(), exp_keys.size());
    end else for (int i = 0; i < exp_keys.size(); i++) begin
      compared++;
      if (press_key[i] != exp_keys[i] || press_len[i] != P) begin
        mismatched++;
        $display("FAIL rand_press[%0d]: got key=%0d len=%0d want key=%0d len=%0d", i, press_key[i], press_len[i], exp_keys[i], P);
      end
    end
    compared++;
    if (err_cnt != exp_err) begin mismatched++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt, exp_err); end
    compared++;
    if (cmd_code !== exp_last) begin mismatched++; $display("FAIL rand_last_code: got %h want %h", cmd_code, exp_last); end
    compared++;
    if (overlap != 0) begin mismatched++; $display("FAIL rand_onehot: got %0d overlapping cycles want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_right();
    test_back_to_back();
    test_stop_error();
    test_glitch();
    test_reset_mid();
    test_reset_low();
`ifdef ARDUINO_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/arduino_cmd_rx.md
ARDUINO_CMD_RX -- requirements
Module: arduino_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter PRESS_CYCLES, default 4, meaning cycles a decoded key output stays high (legal range 1..9*CLKS_PER_BIT).
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port arduino_rx, input, 1, asynchronous UART line from the Arduino (idle high, 8N1, LSB first).
REQ-006 SHALL have port right_arrow_pressed, output, 1, level press for the menu's right shift.
REQ-007 SHALL have port left_arrow_pressed, output, 1, level press for the menu's left shift.
REQ-008 SHALL have port confirm_pressed, output, 1, level press for menu confirm.
REQ-009 SHALL have port cmd_valid, output, 1, one-cycle pulse when a good frame completes.
REQ-010 SHALL have port cmd_code, output, 8, last good received byte, held until the next good frame.
REQ-011 SHALL have port frame_error, output, 1, one-cycle pulse on a bad stop bit (or bad parity, REQ-026).

Function
REQ-012 SHALL pass arduino_rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY per REQ-026).
REQ-014 IDLE: a synchronized 1->0 transition SHALL enter START and clear the bit-timer.
REQ-015 START: at cycle CLKS_PER_BIT/2 (integer divide) the line SHALL be sampled; low -> DATA, high -> IDLE (glitch rejected, no pulses).
REQ-016 DATA: SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifting LSB first; 3-bit index wraps 7->0 on exit to STOP.
REQ-017 STOP: sample CLKS_PER_BIT after bit 7; high -> cmd_valid and cmd_code update in the cycle after the sample, return IDLE; low -> frame_error pulse, byte discarded, cmd_code unchanged, enter WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until synchronized line is high, then IDLE (a break never yields repeated frames).
REQ-019 Decode on cmd_valid: 0x52 ('R') -> right, 0x4C ('L') -> left, 0x0D -> confirm; any other code -> cmd_valid only, no press.
REQ-020 A decoded press SHALL assert its output starting the cycle after cmd_valid for exactly PRESS_CYCLES cycles, then deassert; at most one press output high at any time.
REQ-021 Because PRESS_CYCLES <= 9*CLKS_PER_BIT, back-to-back frames SHALL always give each press a deasserted gap before the next, so the menu edge detector sees every press.
REQ-022 Bit timer SHALL be $clog2(CLKS_PER_BIT)-bit minimum, never overflow; press counter $clog2(PRESS_CYCLES+1) bits.

Reset
REQ-023 Reset SHALL force state IDLE, synchronizer flops to 1, timers/index to 0, cmd_code to 0x00, and all 1-bit outputs to 0 on the next edge.
REQ-024 Reset mid-frame or mid-press SHALL abandon the frame/press with no cmd_valid or frame_error pulse.
REQ-025 After reset release, a line held low SHALL NOT start a frame until a 1->0 transition is seen.

Configuration
REQ-026 With ARDUINO_RX_PARITY_EN defined, frames SHALL be 8E1: PARITY state samples a ninth bit after bit 7; parity mismatch -> frame_error pulse at stop sample, byte discarded, no press; without the macro frames SHALL be 8N1 with no parity state.

Structure
REQ-027 Shared package menu_pkg SHALL hold the command constants CMD_RIGHT=8'h52, CMD_LEFT=8'h4C, CMD_CONFIRM=8'h0D and the state enum type.
REQ-028 One sub-module uart_rx_core (synchronizer, FSM, bit timer, shift register) SHALL be instantiated; decode and press stretching live in the top.

Verification (CLKS_PER_BIT=16, PRESS_CYCLES=4)
REQ-029 Send 0x52 8N1 -> cmd_valid one cycle, cmd_code=0x52, right_arrow_pressed high exactly 4 cycles, left/confirm stay 0.
REQ-030 Send 0x4C then 0x4C back-to-back -> two cmd_valid pulses 160 cycles apart, two separate 4-cycle left presses with a low gap.
REQ-031 Send 0x41 with stop bit forced low -> frame_error one cycle, no cmd_valid, cmd_code keeps 0x4C, FSM waits for line high.
REQ-032 Line low for 5 cycles then high -> no pulses, FSM back in IDLE.
REQ-033 Assert reset at DATA bit 4 of 0x0D -> no pulses, cmd_code=0x00, next full 0x0D frame gives confirm_pressed for 4 cycles.
REQ-034 With ARDUINO_RX_PARITY_EN, send 0x52 with odd parity bit -> frame_error, no press; correct parity -> right press.
